// File: rtl/lisa_imem_fetchq.sv
// LISA byte-addressed instruction memory: strobed loader port, registered handshaked fetch window,
// post-reset clear sequencer. Define LISA_IMEM_WRAP_EN to wrap fetch addresses modulo MEM_BYTES.
module lisa_imem_fetchq #(
  parameter int unsigned MEM_BYTES   = 512,
  parameter int unsigned FETCH_BYTES = 16,
  parameter int unsigned LOAD_BYTES  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [15:0]              load_addr,
  input  logic [LOAD_BYTES*8-1:0]  load_data,
  input  logic [LOAD_BYTES-1:0]    load_strb,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [15:0]              req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [FETCH_BYTES*8-1:0] rsp_window,
  output logic [15:0]              rsp_addr,
  output logic [FETCH_BYTES-1:0]   rsp_oob,
  output logic                     busy
);

  localparam int unsigned AW       = $clog2(MEM_BYTES);
  localparam int unsigned ClrBeats = MEM_BYTES / LOAD_BYTES;
  localparam int unsigned CW       = (ClrBeats > 1) ? $clog2(ClrBeats) : 1;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e                   state_q, state_d;
  logic [CW-1:0]            clr_cnt_q, clr_cnt_d;
  logic [7:0]               mem_q [MEM_BYTES];

  logic                     rsp_valid_q;
  logic [FETCH_BYTES*8-1:0] rsp_window_q;
  logic [15:0]              rsp_addr_q;
  logic [FETCH_BYTES-1:0]   rsp_oob_q;

  logic                     clr_en;
  logic [AW-1:0]            clr_base;
  logic                     load_fire;
  logic                     req_fire;
  logic [16:0]              lane_addr [LOAD_BYTES];
  logic [LOAD_BYTES-1:0]    lane_we;
  logic [FETCH_BYTES*8-1:0] win_d;
  logic [FETCH_BYTES-1:0]   oob_d;

  // Clear sequencer
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      StInit: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == CW'(ClrBeats - 1)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StInit;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign busy       = (state_q == StInit);
  assign load_ready = (state_q == StRun);
  assign req_ready  = (state_q == StRun) && !load_valid && (!rsp_valid_q || rsp_ready);

  assign clr_en    = rst_n && (state_q == StInit);
  assign clr_base  = AW'(32'(clr_cnt_q) * LOAD_BYTES);
  assign load_fire = rst_n && load_valid && load_ready;
  assign req_fire  = rst_n && req_valid && req_ready;

  // Lane addresses are 17 bits so a beat near 0xFFFF drops lanes instead of wrapping to 0
  always_comb begin
    lane_we = '0;
    for (int k = 0; k < LOAD_BYTES; k++) begin
      lane_addr[k] = {1'b0, load_addr} + 17'(k);
      lane_we[k]   = load_fire && load_strb[k] && (lane_addr[k] < 17'(MEM_BYTES));
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < LOAD_BYTES; k++) begin
      if (clr_en) begin
        mem_q[clr_base + AW'(k)] <= 8'h00;
      end else if (lane_we[k]) begin
        mem_q[lane_addr[k][AW-1:0]] <= load_data[8*k +: 8];
      end
    end
  end

  // Fetch window read
`ifdef LISA_IMEM_WRAP_EN
  logic [AW-1:0] fetch_idx;
  logic          unused_req_addr;
  assign unused_req_addr = ^req_addr;

  always_comb begin
    win_d     = '0;
    oob_d     = '0;
    fetch_idx = '0;
    for (int i = 0; i < FETCH_BYTES; i++) begin
      fetch_idx          = req_addr[AW-1:0] + AW'(i);
      win_d[8*i +: 8]    = mem_q[fetch_idx];
    end
  end
`else
  logic [16:0] fetch_addr;

  always_comb begin
    win_d      = '0;
    oob_d      = '0;
    fetch_addr = '0;
    for (int i = 0; i < FETCH_BYTES; i++) begin
      fetch_addr = {1'b0, req_addr} + 17'(i);
      if (fetch_addr < 17'(MEM_BYTES)) begin
        win_d[8*i +: 8] = mem_q[fetch_addr[AW-1:0]];
      end else begin
        oob_d[i] = 1'b1;
      end
    end
  end
`endif

  // Response registers hold while the consumer stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_window_q <= '0;
      rsp_addr_q   <= '0;
      rsp_oob_q    <= '0;
    end else if (req_fire) begin
      rsp_valid_q  <= 1'b1;
      rsp_window_q <= win_d;
      rsp_addr_q   <= req_addr;
      rsp_oob_q    <= oob_d;
    end else if (rsp_ready) begin
      rsp_valid_q  <= 1'b0;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_window = rsp_window_q;
  assign rsp_addr   = rsp_addr_q;
  assign rsp_oob    = rsp_oob_q;

endmodule

// File: tb/tb_lisa_imem_fetchq.sv
// Bench for lisa_imem_fetchq: directed scenarios plus random traffic against a byte-array model.
module tb_lisa_imem_fetchq;

  localparam int unsigned MB = 512;
  localparam int unsigned FB = 16;
  localparam int unsigned LB = 4;
  localparam int unsigned ClrCycles = MB / LB;

  logic            clk;
  logic            rst_n;
  logic            load_valid;
  logic            load_ready;
  logic [15:0]     load_addr;
  logic [LB*8-1:0] load_data;
  logic [LB-1:0]   load_strb;
  logic            req_valid;
  logic            req_ready;
  logic [15:0]     req_addr;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [FB*8-1:0] rsp_window;
  logic [15:0]     rsp_addr;
  logic [FB-1:0]   rsp_oob;
  logic            busy;

  lisa_imem_fetchq #(
    .MEM_BYTES  (MB),
    .FETCH_BYTES(FB),
    .LOAD_BYTES (LB)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_addr (load_addr),
    .load_data (load_data),
    .load_strb (load_strb),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_window(rsp_window),
    .rsp_addr  (rsp_addr),
    .rsp_oob   (rsp_oob),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: whole memory, remaining clear cycles, held response
  logic [7:0]      m_mem [MB];
  int              m_busy_left = 0;
  bit              m_known = 0;
  logic            m_rsp_valid;
  logic [FB*8-1:0] m_rsp_window;
  logic [15:0]     m_rsp_addr;
  logic [FB-1:0]   m_rsp_oob;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int unsigned a = 0; a < MB; a++) m_mem[a] = 8'h00;
    m_busy_left  = ClrCycles;
    m_known      = 1;
    m_rsp_valid  = 1'b0;
    m_rsp_window = '0;
    m_rsp_addr   = '0;
    m_rsp_oob    = '0;
  endfunction

  function automatic void model_load(input logic [15:0] a, input logic [LB*8-1:0] d,
                                     input logic [LB-1:0] s);
    int unsigned ba;
    for (int unsigned k = 0; k < LB; k++) begin
      ba = 32'(a) + k;
      if (s[k] && ba < MB) m_mem[ba] = d[8*k +: 8];
    end
  endfunction

  function automatic void model_fetch(input logic [15:0] a);
    int unsigned ba;
    m_rsp_window = '0;
    m_rsp_oob    = '0;
    for (int unsigned i = 0; i < FB; i++) begin
      ba = 32'(a) + i;
`ifdef LISA_IMEM_WRAP_EN
      m_rsp_window[8*i +: 8] = m_mem[ba % MB];
`else
      if (ba < MB) m_rsp_window[8*i +: 8] = m_mem[ba];
      else m_rsp_oob[i] = 1'b1;
`endif
    end
    m_rsp_addr  = a;
    m_rsp_valid = 1'b1;
  endfunction

  // One clock: compare at negedge, decide accepts from the model, advance model at posedge
  task automatic cycle();
    logic exp_load_ready, exp_req_ready, ld_acc, rq_acc;
    @(negedge clk);
    exp_load_ready = m_known && (m_busy_left == 0);
    exp_req_ready  = exp_load_ready && !load_valid && (!m_rsp_valid || rsp_ready);
    if (m_known) begin
      check_eq("busy", 128'(busy), 128'(m_busy_left != 0));
      check_eq("load_ready", 128'(load_ready), 128'(exp_load_ready));
      check_eq("req_ready", 128'(req_ready), 128'(exp_req_ready));
      check_eq("rsp_valid", 128'(rsp_valid), 128'(m_rsp_valid));
      check_eq("rsp_window", rsp_window, m_rsp_window);
      check_eq("rsp_addr", 128'(rsp_addr), 128'(m_rsp_addr));
      check_eq("rsp_oob", 128'(rsp_oob), 128'(m_rsp_oob));
    end
    ld_acc = rst_n && load_valid && exp_load_ready;
    rq_acc = rst_n && req_valid && exp_req_ready;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_busy_left > 0) m_busy_left--;
      if (ld_acc) model_load(load_addr, load_data, load_strb);
      if (rq_acc) model_fetch(req_addr);
      else if (rsp_ready) m_rsp_valid = 1'b0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    load_valid = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    load_strb  = '0;
    req_valid  = 1'b0;
    req_addr   = '0;
    rsp_ready  = 1'b1;
  endtask

  task automatic do_load(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    load_strb  = s;
    cycle();
    load_valid = 1'b0;
  endtask

  task automatic do_fetch(input logic [15:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    rsp_ready = 1'b1;
    cycle();
    req_valid = 1'b0;
  endtask

  task automatic reset_and_clear(input string tag);
    int n;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    n = 0;
    while (busy && n < 300) begin
      cycle();
      n++;
    end
    check_eq(tag, 128'(n), 128'(ClrCycles));
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    cycle();
    cycle();
    check_eq("rst_busy", 128'(busy), 128'(1));
    check_eq("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    check_eq("rst_req_ready", 128'(req_ready), 128'(0));
    reset_and_clear("busy_len");

    // Nonzero contents must be erased by a one-cycle reset pulse
    for (int j = 0; j < 4; j++) do_load(16'(4 * j), 32'hA5A5A5A5, 4'hF);
    do_fetch(16'h0000);
    check_eq("preload_win", rsp_window, {4{32'hA5A5A5A5}});
    cycle();
    reset_and_clear("busy_len2");
    do_fetch(16'h0000);
    check_eq("clr_win", rsp_window, 128'h0);
    check_eq("clr_oob", 128'(rsp_oob), 128'h0);
    cycle();

    // Strobed load, fetched the very next cycle
    do_load(16'h0010, 32'hDDCCBBAA, 4'b1011);
    do_fetch(16'h0010);
    check_eq("ld_fetch", 128'(rsp_window[31:0]), 128'(32'hDD00BBAA));
    cycle();

    // Window straddling the top of memory
    do_load(16'h01F8, 32'h44332211, 4'hF);
    do_load(16'h01FC, 32'h88776655, 4'hF);
    do_load(16'h0000, 32'h0D0C0B0A, 4'hF);
    do_load(16'h0004, 32'h1F1E1D1C, 4'hF);
    do_load(16'h01FE, 32'hEEEEEEEE, 4'b1100);
    do_fetch(16'h01F8);
    check_eq("bnd_lo", 128'(rsp_window[63:0]), 128'(64'h8877665544332211));
`ifdef LISA_IMEM_WRAP_EN
    check_eq("bnd_hi", 128'(rsp_window[127:64]), 128'(64'h1F1E1D1C0D0C0B0A));
    check_eq("bnd_oob", 128'(rsp_oob), 128'(16'h0000));
`else
    check_eq("bnd_hi", 128'(rsp_window[127:64]), 128'(64'h0));
    check_eq("bnd_oob", 128'(rsp_oob), 128'(16'hFF00));
`endif
    cycle();

    // Backpressure: response frozen, later load only seen by the next fetch
    do_load(16'h0020, 32'h11111111, 4'hF);
    req_valid = 1'b1;
    req_addr  = 16'h0020;
    cycle();
    rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      load_valid = (c == 2);
      load_addr  = 16'h0020;
      load_data  = 32'h22222222;
      load_strb  = 4'hF;
      cycle();
      check_eq("bp_hold", 128'(rsp_window[31:0]), 128'(32'h11111111));
      check_eq("bp_valid", 128'(rsp_valid), 128'(1));
      load_valid = 1'b0;
      #1;
      check_eq("bp_req_ready", 128'(req_ready), 128'(0));
    end
    rsp_ready = 1'b1;
    cycle();
    check_eq("bp_new", 128'(rsp_window[31:0]), 128'(32'h22222222));
    req_valid = 1'b0;
    cycle();

    // Loader wins over a simultaneous fetch
    load_valid = 1'b1;
    load_addr  = 16'h0030;
    load_data  = 32'hCAFEF00D;
    load_strb  = 4'hF;
    req_valid  = 1'b1;
    req_addr   = 16'h0030;
    #1;
    check_eq("prio_req_ready", 128'(req_ready), 128'(0));
    check_eq("prio_load_ready", 128'(load_ready), 128'(1));
    cycle();
    load_valid = 1'b0;
    cycle();
    check_eq("prio_win", 128'(rsp_window[31:0]), 128'(32'hCAFEF00D));
    req_valid = 1'b0;
    cycle();

    // Reset during the clear sequence restarts it in full
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    repeat (60) cycle();
    check_eq("midinit_busy", 128'(busy), 128'(1));
    reset_and_clear("midinit_len");

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst_n      = ($urandom_range(0, 999) != 0);
      load_valid = ($urandom_range(0, 9) < 3);
      load_addr  = ($urandom_range(0, 9) == 0) ? 16'(16'hFFF8 + $urandom_range(0, 7))
                                               : 16'($urandom_range(0, 520));
      load_data  = $urandom;
      load_strb  = 4'($urandom_range(0, 15));
      req_valid  = ($urandom_range(0, 9) < 6);
      req_addr   = ($urandom_range(0, 9) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15))
                                               : 16'($urandom_range(0, 528));
      rsp_ready  = ($urandom_range(0, 9) < 7);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
